// File: rtl/neo_input_conditioner.sv
// neo_input_conditioner: turns BL616 pad words into active-low NeoGeo player/system/start/coin signals
// with sampled debounce, SOCD cleaning, per-button autofire and a one-shot coin pulse per player.
module neo_input_conditioner #(
  parameter int NUM_PLAYERS = 2,
  parameter int SAMPLE_DIV = 96000,
  parameter int DEB_DEPTH = 4,
  parameter int AUTOFIRE_TICKS = 33,
  parameter int COIN_PULSE_TICKS = 50,
  parameter int COIN_GAP_TICKS = 50,
  parameter int SOCD_NEUTRAL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [16*NUM_PLAYERS-1:0] joy,
  input  logic [4*NUM_PLAYERS-1:0]  af_en,
  input  logic [1:0]                dipsw,
  output logic [8*NUM_PLAYERS-1:0]  neo_p,
  output logic [7:0]                neo_system,
  output logic [NUM_PLAYERS-1:0]    neo_start_n,
  output logic [NUM_PLAYERS-1:0]    neo_coin_n
);
  localparam int NB = 12 * NUM_PLAYERS;
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int AW = $clog2(AUTOFIRE_TICKS + 1);
  localparam int CW = $clog2((COIN_PULSE_TICKS > COIN_GAP_TICKS ? COIN_PULSE_TICKS : COIN_GAP_TICKS) + 1);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_t;
  logic [TW-1:0] tcnt;
  logic tick;
  logic unused_joy;
  logic [NB-1:0][DEB_DEPTH-1:0] sr, sr_nxt;
  logic [NB-1:0] stable, stable_nxt;
  logic [NUM_PLAYERS-1:0] phase, af_held, ud, lr, start_nxt, coin_nxt;
  logic [NUM_PLAYERS-1:0][AW-1:0] af_cnt;
  logic [NUM_PLAYERS-1:0][CW-1:0] coin_cnt;
  coin_t coin_st [NUM_PLAYERS];
  logic [8*NUM_PLAYERS-1:0] p_nxt;
  assign tick = tcnt == TW'(SAMPLE_DIV - 1);
  assign unused_joy = ^joy;
  always_comb begin
    sr_nxt = '0;
    stable_nxt = stable;
    for (int b = 0; b < NB; b++) begin
      sr_nxt[b] = {sr[b][DEB_DEPTH-2:0], joy[16*(b/12) + b%12]};
      stable_nxt[b] = !tick ? stable[b] : &sr_nxt[b] ? 1'b1 : ~|sr_nxt[b] ? 1'b0 : stable[b];
    end
  end
  // Output terms come from the registered stable state so every output lags the stable update by one clock.
  always_comb begin
    {ud, lr, af_held, start_nxt, coin_nxt} = '0;
    p_nxt = '1;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      ud[p] = SOCD_NEUTRAL != 0 && stable[12*p+4] && stable[12*p+5];
      lr[p] = SOCD_NEUTRAL != 0 && stable[12*p+6] && stable[12*p+7];
      af_held[p] = |(af_en[4*p +: 4] & stable[12*p +: 4]);
      p_nxt[8*p+0] = ~(stable[12*p+4] & ~ud[p]);
      p_nxt[8*p+1] = ~(stable[12*p+5] & ~ud[p]);
      p_nxt[8*p+2] = ~(stable[12*p+6] & ~lr[p]);
      p_nxt[8*p+3] = ~(stable[12*p+7] & ~lr[p]);
      for (int k = 0; k < 4; k++)
        p_nxt[8*p+4+k] = ~(af_en[4*p+k] & stable[12*p+k] ? phase[p] : stable[12*p+k]);
      start_nxt[p] = ~stable[12*p+9];
      coin_nxt[p] = coin_st[p] != PULSE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      sr <= '0;
      stable <= '0;
      af_cnt <= '0;
      phase <= '1;
      coin_cnt <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) coin_st[p] <= IDLE;
      neo_p <= '1;
      neo_system <= '1;
      neo_start_n <= '1;
      neo_coin_n <= '1;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      if (tick) sr <= sr_nxt;
      stable <= stable_nxt;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!af_held[p]) begin
          af_cnt[p] <= '0;
          phase[p] <= 1'b1;
        end else if (tick) begin
          af_cnt[p] <= af_cnt[p] == AW'(AUTOFIRE_TICKS - 1) ? '0 : af_cnt[p] + 1'b1;
          if (af_cnt[p] == AW'(AUTOFIRE_TICKS - 1)) phase[p] <= ~phase[p];
        end
        // Select edges are only seen from IDLE, so edges during PULSE/GAP are dropped.
        if (coin_st[p] == IDLE) begin
          if (stable_nxt[12*p+8] && !stable[12*p+8]) begin
            coin_st[p] <= PULSE;
            coin_cnt[p] <= '0;
          end
        end else if (tick) begin
          if (coin_cnt[p] == CW'(coin_st[p] == PULSE ? COIN_PULSE_TICKS - 1 : COIN_GAP_TICKS - 1)) begin
            coin_st[p] <= coin_st[p] == PULSE ? GAP : IDLE;
            coin_cnt[p] <= '0;
          end else coin_cnt[p] <= coin_cnt[p] + 1'b1;
        end
      end
      neo_p <= p_nxt;
      neo_start_n <= start_nxt;
      neo_coin_n <= coin_nxt;
      neo_system <= {~stable[10], ~stable[11], coin_nxt[1], coin_nxt[0], start_nxt[1], start_nxt[0], ~dipsw[1], ~dipsw[0]};
    end
  end
endmodule

// File: tb/tb_neo_input_conditioner.sv
// tb_neo_input_conditioner: table-driven steady-state vectors plus timed sequences for debounce,
// SOCD, autofire, coin pulse and mid-pulse reset.
module tb_neo_input_conditioner;
  logic clk = 0, reset = 1;
  logic [63:0] joy = '0;
  logic [15:0] af_en = '0;
  logic [1:0] dipsw = 2'b11;
  logic [31:0] neo_p, p_b, p_g;
  logic [7:0] neo_system, sys_b, sys_g;
  logic [3:0] start_n, start_b, start_g, coin_n, coin_b, coin_g;
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int low_a = 0, fall_a = 0, low_g = 0, fall_g = 0;
  logic prev_a = 1, prev_g = 1;
  typedef struct {
    logic [63:0] joy;
    logic [1:0]  dip;
    logic [31:0] p;
    logic [7:0]  sys;
    logic [3:0]  st;
  } vec_t;
  vec_t vt[13];
  vec_t sb[$];
  vec_t e;

  always #5 clk = ~clk;

  neo_input_conditioner #(.NUM_PLAYERS(4), .SAMPLE_DIV(4), .DEB_DEPTH(3), .AUTOFIRE_TICKS(2),
    .COIN_PULSE_TICKS(3), .COIN_GAP_TICKS(2), .SOCD_NEUTRAL(1)) u_dut (
    .clk(clk), .reset(reset), .joy(joy), .af_en(af_en), .dipsw(dipsw),
    .neo_p(neo_p), .neo_system(neo_system), .neo_start_n(start_n), .neo_coin_n(coin_n));
  neo_input_conditioner #(.NUM_PLAYERS(4), .SAMPLE_DIV(4), .DEB_DEPTH(3), .AUTOFIRE_TICKS(2),
    .COIN_PULSE_TICKS(3), .COIN_GAP_TICKS(2), .SOCD_NEUTRAL(0)) u_socd0 (
    .clk(clk), .reset(reset), .joy(joy), .af_en(af_en), .dipsw(dipsw),
    .neo_p(p_b), .neo_system(sys_b), .neo_start_n(start_b), .neo_coin_n(coin_b));
  // Long gap so a second Select edge can land inside GAP despite debounce latency.
  neo_input_conditioner #(.NUM_PLAYERS(4), .SAMPLE_DIV(4), .DEB_DEPTH(3), .AUTOFIRE_TICKS(2),
    .COIN_PULSE_TICKS(3), .COIN_GAP_TICKS(8), .SOCD_NEUTRAL(1)) u_gap (
    .clk(clk), .reset(reset), .joy(joy), .af_en(af_en), .dipsw(dipsw),
    .neo_p(p_g), .neo_system(sys_g), .neo_start_n(start_g), .neo_coin_n(coin_g));

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    low_a <= low_a + (coin_n[2] ? 0 : 1);
    fall_a <= fall_a + ((prev_a && !coin_n[2]) ? 1 : 0);
    prev_a <= coin_n[2];
    low_g <= low_g + (coin_g[2] ? 0 : 1);
    fall_g <= fall_g + ((prev_g && !coin_g[2]) ? 1 : 0);
    prev_g <= coin_g[2];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_align();
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
  endtask

  initial begin
    int n, la, fa, lg, fg;
    logic changed;
    logic [31:0] pat;
    vt[0]  = '{64'h0, 2'b11, 32'hFFFFFFFF, 8'hFC, 4'hF};
    vt[1]  = '{64'h10, 2'b00, 32'hFFFFFFFE, 8'hFF, 4'hF};
    vt[2]  = '{64'h30, 2'b01, 32'hFFFFFFFF, 8'hFE, 4'hF};
    vt[3]  = '{64'hD0, 2'b11, 32'hFFFFFFFE, 8'hFC, 4'hF};
    vt[4]  = '{64'h0F, 2'b10, 32'hFFFFFF0F, 8'hFD, 4'hF};
    vt[5]  = '{64'h200, 2'b11, 32'hFFFFFFFF, 8'hF8, 4'hE};
    vt[6]  = '{64'h0200_0000, 2'b11, 32'hFFFFFFFF, 8'hF4, 4'hD};
    vt[7]  = '{64'h0200_0200_0000_0000, 2'b11, 32'hFFFFFFFF, 8'hFC, 4'h3};
    vt[8]  = '{64'h0C00, 2'b11, 32'hFFFFFFFF, 8'h3C, 4'hF};
    vt[9]  = '{64'h0800_0000, 2'b11, 32'hFFFFFFFF, 8'hFC, 4'hF};
    vt[10] = '{64'h0070_00A0_0000_0000, 2'b11, 32'hFBF5FFFF, 8'hFC, 4'hF};
    vt[11] = '{64'hF000, 2'b11, 32'hFFFFFFFF, 8'hFC, 4'hF};
    vt[12] = '{64'h0018_0000, 2'b11, 32'hFFFF7EFF, 8'hFC, 4'hF};

    joy = '1;
    reset = 1;
    clocks(5);
    check("reset_p", neo_p, 32'hFFFFFFFF);
    check("reset_sys", neo_system, 8'hFF);
    check("reset_start", start_n, 4'hF);
    check("reset_coin", coin_n, 4'hF);
    joy = '0;
    reset = 0;
    clocks(1);
    check("post_reset_sys", neo_system, 8'hFC);
    check("post_reset_p", neo_p, 32'hFFFFFFFF);

    for (int i = 0; i < 13; i++) begin
      joy = vt[i].joy;
      dipsw = vt[i].dip;
      sb.push_back(vt[i]);
      clocks(24);
      e = sb.pop_front();
      check($sformatf("vec%0d_p", i), neo_p, e.p);
      check($sformatf("vec%0d_sys", i), neo_system, e.sys);
      check($sformatf("vec%0d_start", i), start_n, e.st);
      check($sformatf("vec%0d_coin", i), coin_n, 4'hF);
    end
    joy = '0;
    dipsw = 2'b11;
    clocks(24);

    tick_align();
    joy[20] = 1'b1;
    n = 0;
    while (neo_p[8] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("deb_latency", n, 13);
    joy[20] = 1'b0;
    clocks(24);
    check("deb_release", neo_p[8], 1'b1);
    tick_align();
    changed = 0;
    for (int i = 0; i < 10; i++) begin
      joy[20] = ~joy[20];
      repeat (4) begin
        @(negedge clk);
        if (neo_p[8] !== 1'b1) changed = 1;
      end
    end
    check("deb_bounce", changed, 1'b0);
    joy = '0;
    clocks(24);

    joy = 64'h30;
    clocks(24);
    check("socd_ud_neutral", neo_p[1:0], 2'b11);
    check("socd_ud_pass", p_b[1:0], 2'b00);
    joy = 64'hC0;
    clocks(24);
    check("socd_lr_neutral", neo_p[3:2], 2'b11);
    check("socd_lr_pass", p_b[3:2], 2'b00);
    joy = '0;
    clocks(24);

    af_en[0] = 1'b1;
    joy[0] = 1'b1;
    n = 0;
    while (neo_p[4] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("af_first_pressed", neo_p[4], 1'b0);
    for (int i = 0; i < 32; i++) begin
      pat[i] = neo_p[4];
      @(negedge clk);
    end
    check("af_pattern", pat, 32'hFF00FF00);
    joy[0] = 1'b0;
    clocks(24);
    check("af_release", neo_p[4], 1'b1);
    af_en = '0;
    clocks(8);

    la = low_a; fa = fall_a; lg = low_g; fg = fall_g;
    tick_align();
    joy[40] = 1'b1;
    clocks(160);
    joy[40] = 1'b0;
    clocks(24);
    check("coin_hold_low", low_a - la, 12);
    check("coin_hold_pulses", fall_a - fa, 1);
    check("coin_hold_low_gap", low_g - lg, 12);
    check("coin_hold_pulses_gap", fall_g - fg, 1);
    la = low_a; fa = fall_a;
    tick_align();
    joy[40] = 1'b1;
    clocks(40);
    joy[40] = 1'b0;
    clocks(24);
    check("coin_repress_low", low_a - la, 12);
    check("coin_repress_pulses", fall_a - fa, 1);
    clocks(40);

    la = low_a; fa = fall_a; lg = low_g; fg = fall_g;
    tick_align();
    joy[40] = 1'b1;
    clocks(12);
    joy[40] = 1'b0;
    clocks(12);
    joy[40] = 1'b1;
    clocks(80);
    joy[40] = 1'b0;
    clocks(24);
    check("coin_gap_drop_pulses", fall_g - fg, 1);
    check("coin_gap_drop_low", low_g - lg, 12);
    check("coin_after_gap_pulses", fall_a - fa, 2);
    check("coin_after_gap_low", low_a - la, 24);
    clocks(40);

    tick_align();
    joy[8] = 1'b1;
    n = 0;
    while (neo_system[4] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("coin1_pulse", neo_system[4], 1'b0);
    clocks(2);
    reset = 1'b1;
    clocks(1);
    check("midreset_sys_coin", neo_system[4], 1'b1);
    check("midreset_coin_n", coin_n[0], 1'b1);
    check("midreset_p", neo_p, 32'hFFFFFFFF);
    joy[8] = 1'b0;
    clocks(1);
    reset = 1'b0;
    changed = 0;
    repeat (40) begin
      @(negedge clk);
      if (neo_system[4] !== 1'b1) changed = 1;
    end
    check("idle_after_reset", changed, 1'b0);
    joy[8] = 1'b1;
    n = 0;
    while (neo_system[4] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("coin_after_reset", neo_system[4], 1'b0);
    check("coin_n_after_reset", coin_n[0], 1'b0);
    joy = '0;
    clocks(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
